// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the data-memory access controller: data width,
// byte-offset width, request size encodings, FSM states and size helpers.
package mem_access_ctrl_pkg;

    localparam int unsigned WORD_W = 64;
    localparam int unsigned OFF_W  = 3;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'b00,
        SZ_HALF  = 2'b01,
        SZ_WORD  = 2'b10,
        SZ_DWORD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        RESP = 2'b11
    } state_e;

    // Offset bits that must be zero for a naturally aligned access.
    function automatic logic [OFF_W-1:0] size_low_mask(input size_e sz);
        case (sz)
            SZ_BYTE: return 3'b000;
            SZ_HALF: return 3'b001;
            SZ_WORD: return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

    // Byte lanes covered by an access of the given size at offset 0.
    function automatic logic [7:0] size_lanes(input size_e sz);
        case (sz)
            SZ_BYTE: return 8'h01;
            SZ_HALF: return 8'h03;
            SZ_WORD: return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_merge.sv
// Combinational byte-lane logic for sub-word accesses (little-endian lanes).
//   size_i   : access size
//   off_i    : byte offset inside the word
//   signed_i : sign-extend the load field
//   rword_i  : word read from memory
//   wdata_i  : right-aligned store data
//   merged_o : rword_i with the target lanes replaced by wdata_i
//   load_o   : target field shifted to bit 0 and extended
module mem_lane_merge
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned WORD         = WORD_W,
    parameter int unsigned ALIGN_MASK_W = OFF_W
) (
    input  size_e                   size_i,
    input  logic [ALIGN_MASK_W-1:0] off_i,
    input  logic                    signed_i,
    input  logic [WORD-1:0]         rword_i,
    input  logic [WORD-1:0]         wdata_i,
    output logic [WORD-1:0]         merged_o,
    output logic [WORD-1:0]         load_o
);

    localparam int unsigned LANES = WORD / 8;

    logic [WORD-1:0]  shifted;
    logic [WORD-1:0]  wshift;
    logic [WORD-1:0]  bmask;
    logic [LANES-1:0] lane_en;

    always_comb begin
        shifted = rword_i >> {off_i, 3'b000};
        wshift  = wdata_i << {off_i, 3'b000};
        lane_en = LANES'(size_lanes(size_i)) << off_i;
        bmask   = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            bmask[8*i +: 8] = {8{lane_en[i]}};
        end
        merged_o = (rword_i & ~bmask) | (wshift & bmask);

        case (size_i)
            SZ_BYTE:  load_o = {{(WORD-8){signed_i & shifted[7]}},   shifted[7:0]};
            SZ_HALF:  load_o = {{(WORD-16){signed_i & shifted[15]}}, shifted[15:0]};
            SZ_WORD:  load_o = {{(WORD-32){signed_i & shifted[31]}}, shifted[31:0]};
            default:  load_o = shifted;  // dword offset is always 0 here
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Requester side of the data-memory interface. Accepts one load/store at a
// time, performs byte/half/word32/dword accesses on a 64-bit-word memory
// (read-modify-write for sub-word stores) and returns extended load data.
// Build option: MEM_ACCESS_ALIGN_CHECK_EN enables misalignment errors;
// without it, low address bits are rounded down to natural alignment.
// Ports:
//   clk, rst                 : clock, async active-high reset
//   req_valid/req_ready      : request handshake
//   req_write/size/signed    : request type
//   req_addr/req_wdata       : byte address, right-aligned store data
//   rsp_valid/rsp_rdata/rsp_err : one-cycle completion strobe and result
//   MemRead/MemWrite/mem_addr   : memory strobes and word address
//   mem_data                 : shared bidirectional data bus
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned WORD         = WORD_W,
    parameter int unsigned ALIGN_MASK_W = OFF_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [1:0]      req_size,
    input  logic            req_signed,
    input  logic [WORD-1:0] req_addr,
    input  logic [WORD-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [WORD-1:0] rsp_rdata,
    output logic            rsp_err,
    output logic            MemRead,
    output logic            MemWrite,
    output logic [WORD-1:0] mem_addr,
    inout  wire logic [WORD-1:0] mem_data
);

    state_e          state_q, state_d;
    logic [WORD-1:0] addr_q,  addr_d;
    size_e           size_q,  size_d;
    logic            signed_q, signed_d;
    logic            write_q, write_d;
    logic [WORD-1:0] wdata_q, wdata_d;
    logic [WORD-1:0] word_q,  word_d;
    logic [WORD-1:0] rdata_q, rdata_d;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    logic            err_q,   err_d;
`endif

    logic [ALIGN_MASK_W-1:0] low_mask;
    logic                    misalign;
    logic [WORD-1:0]         acc_addr;
    logic [WORD-1:0]         lane_rword;
    logic [WORD-1:0]         merged;
    logic [WORD-1:0]         load_val;

    assign low_mask = size_low_mask(size_e'(req_size));

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    assign misalign = |(req_addr[ALIGN_MASK_W-1:0] & low_mask);
    assign acc_addr = req_addr;
`else
    assign misalign = 1'b0;
    assign acc_addr = {req_addr[WORD-1:ALIGN_MASK_W], req_addr[ALIGN_MASK_W-1:0] & ~low_mask};
`endif

    // Extraction works on the live bus during RD; merging uses the captured word in WR.
    assign lane_rword = (state_q == RD) ? mem_data : word_q;

    mem_lane_merge #(
        .WORD         (WORD),
        .ALIGN_MASK_W (ALIGN_MASK_W)
    ) u_lane (
        .size_i   (size_q),
        .off_i    (addr_q[ALIGN_MASK_W-1:0]),
        .signed_i (signed_q),
        .rword_i  (lane_rword),
        .wdata_i  (wdata_q),
        .merged_o (merged),
        .load_o   (load_val)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        size_d   = size_q;
        signed_d = signed_q;
        write_d  = write_q;
        wdata_d  = wdata_q;
        word_d   = word_q;
        rdata_d  = rdata_q;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
        err_d    = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d   = acc_addr;
                    size_d   = size_e'(req_size);
                    signed_d = req_signed;
                    write_d  = req_write;
                    wdata_d  = req_wdata;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
                    err_d    = misalign;
`endif
                    if (misalign) begin
                        state_d = RESP;
                        rdata_d = '0;
                    end else if (req_write && (size_e'(req_size) == SZ_DWORD)) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                word_d = mem_data;
                if (write_q) begin
                    state_d = WR;
                end else begin
                    rdata_d = load_val;
                    state_d = RESP;
                end
            end
            WR: begin
                rdata_d = '0;
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            size_q   <= SZ_BYTE;
            signed_q <= 1'b0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            word_q   <= '0;
            rdata_q  <= '0;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            write_q  <= write_d;
            wdata_q  <= wdata_d;
            word_q   <= word_d;
            rdata_q  <= rdata_d;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
            err_q    <= err_d;
`endif
        end
    end

    // Strobes decode straight from the state register so reset drops them at once.
    assign req_ready = (state_q == IDLE);
    assign MemRead   = (state_q == RD);
    assign MemWrite  = (state_q == WR);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign mem_addr  = {addr_q[WORD-1:ALIGN_MASK_W], {ALIGN_MASK_W{1'b0}}};
    assign mem_data  = (state_q == WR) ? merged : 'z;

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    assign rsp_err = (state_q == RESP) && err_q;
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomised bench for mem_access_ctrl against a word-array reference model.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        rsp_err;
    logic        MemRead;
    logic        MemWrite;
    logic [63:0] mem_addr;
    wire  [63:0] mem_data;

    logic [63:0] tbmem   [16];
    logic [63:0] ref_mem [16];

    int n_checks = 0;
    int n_pass   = 0;
    int rd_cyc   = 0;
    int wr_cyc   = 0;
    int overlap  = 0;

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data)
    );

    // Word-organised memory: combinational read, write committed on the clock edge.
    assign mem_data = MemRead ? tbmem[mem_addr[6:3]] : 'z;
    always @(posedge clk) if (MemWrite) tbmem[mem_addr[6:3]] <= mem_data;

    always @(negedge clk) begin
        if (MemRead) rd_cyc++;
        if (MemWrite) wr_cyc++;
        if (MemRead && MemWrite) overlap++;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic randomize_fields();
        req_write  = 1'($urandom);
        req_size   = 2'($urandom);
        req_signed = 1'($urandom);
        req_addr   = {$urandom, $urandom};
        req_wdata  = {$urandom, $urandom};
    endtask

    // Call at a negedge. With hold=1, req_valid stays high with junk while busy
    // and the task returns at the response cycle without releasing req_valid.
    task automatic do_req(input bit wr, input bit [1:0] sz, input bit sg,
                          input bit [63:0] a, input bit [63:0] wd, input bit hold);
        int unsigned n;
        int unsigned off;
        int          lat;
        int          bnd;
        int          exp_lat;
        int          exp_rd_cyc;
        int          exp_wr_cyc;
        bit          exp_err;
        bit          got_rsp;
        bit          busy_ready;
        bit [63:0]   ea;
        bit [63:0]   lmask;
        bit [63:0]   w;
        bit [63:0]   field;
        bit [63:0]   exp_rd;
        bit [3:0]    idx;

        n = 1 << sz;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
        exp_err = (a % n) != 0;
        ea      = a;
`else
        exp_err = 1'b0;
        ea      = a - (a % n);
`endif
        lmask  = (n == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * n)) - 64'd1);
        off    = int'(ea % 8);
        idx    = ea[6:3];
        w      = ref_mem[idx];
        exp_rd = '0;
        if (exp_err) begin
            exp_lat = 1; exp_rd_cyc = 0; exp_wr_cyc = 0;
        end else if (wr) begin
            ref_mem[idx] = (w & ~(lmask << (8 * off))) | ((wd & lmask) << (8 * off));
            exp_lat    = (n < 8) ? 3 : 2;
            exp_rd_cyc = (n < 8) ? 1 : 0;
            exp_wr_cyc = 1;
        end else begin
            field = (w >> (8 * off)) & lmask;
            if (sg && n < 8 && field[8 * n - 1]) field = field | ~lmask;
            exp_rd = field;
            exp_lat = 2; exp_rd_cyc = 1; exp_wr_cyc = 0;
        end

        req_valid  = 1'b1;
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        for (bnd = 0; !req_ready && bnd < 10; bnd++) @(negedge clk);
        check_eq("ready_wait", req_ready, 1'b1);

        @(posedge clk);
        #1;
        rd_cyc = 0;
        wr_cyc = 0;
        if (hold) randomize_fields();
        else req_valid = 1'b0;

        lat = 0; got_rsp = 0; busy_ready = 0;
        while (lat < 8) begin
            @(negedge clk);
            lat++;
            if (req_ready) busy_ready = 1;
            if (rsp_valid) begin
                got_rsp = 1;
                break;
            end
        end
        check_eq("rsp_seen",   got_rsp, 1'b1);
        check_eq("latency",    lat, exp_lat);
        check_eq("rdata",      rsp_rdata, exp_rd);
        check_eq("err",        rsp_err, exp_err);
        check_eq("rd_cycles",  rd_cyc, exp_rd_cyc);
        check_eq("wr_cycles",  wr_cyc, exp_wr_cyc);
        check_eq("ready_busy", busy_ready, 1'b0);

        if (!hold) begin
            @(negedge clk);
            check_eq("rsp_pulse", rsp_valid, 1'b0);
            check_eq("rdata_hold", rsp_rdata, exp_rd);
        end
    endtask

    initial begin
        logic [63:0] saved;

        rst = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 16; i++) begin
            tbmem[i]   = {$urandom, $urandom};
            ref_mem[i] = tbmem[i];
        end
        #1;
        check_eq("rst_ready",  req_ready, 1'b1);
        check_eq("rst_valid",  rsp_valid, 1'b0);
        check_eq("rst_rdata",  rsp_rdata, 64'd0);
        check_eq("rst_rd",     MemRead, 1'b0);
        check_eq("rst_wr",     MemWrite, 1'b0);
        check_eq("rst_addr",   mem_addr, 64'd0);
        #12;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // dword store/load, byte RMW, signed word32 loads, misaligned half
        do_req(1, 2'b11, 0, 64'h10, 64'h1122334455667788, 0);
        do_req(0, 2'b11, 0, 64'h10, 64'h0, 0);
        do_req(1, 2'b00, 0, 64'h13, 64'hAB, 0);
        check_eq("rmw_word", tbmem[2], 64'h11223344AB667788);
        do_req(1, 2'b11, 0, 64'h20, 64'h0000000080000000, 0);
        do_req(0, 2'b10, 1, 64'h20, 64'h0, 0);
        do_req(0, 2'b10, 0, 64'h20, 64'h0, 0);
        do_req(0, 2'b01, 0, 64'h21, 64'h0, 0);

        // back-to-back with req_valid held high
        for (int i = 0; i < 6; i++)
            do_req(1'($urandom), 2'($urandom), 1'($urandom), 64'($urandom_range(0, 127)),
                   {$urandom, $urandom}, 1);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);

        for (int i = 0; i < 150; i++)
            do_req(1'($urandom), 2'($urandom), 1'($urandom), 64'($urandom_range(0, 127)),
                   {$urandom, $urandom}, 1'($urandom));
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // reset during the WR cycle of a byte RMW at 0x13
        saved = tbmem[2];
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 64'h13; req_wdata = {$urandom, $urandom};
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check_eq("rmw_rd_phase", MemRead, 1'b1);
        @(negedge clk);
        check_eq("rmw_wr_phase", MemWrite, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_wr",    MemWrite, 1'b0);
        check_eq("mid_rst_rd",    MemRead, 1'b0);
        check_eq("mid_rst_ready", req_ready, 1'b1);
        check_eq("mid_rst_valid", rsp_valid, 1'b0);
        check_eq("mid_rst_err",   rsp_err, 1'b0);
        check_eq("mid_rst_rdata", rsp_rdata, 64'd0);
        check_eq("mid_rst_addr",  mem_addr, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_no_commit", tbmem[2], saved);

        check_eq("no_overlap", overlap, 0);
        for (int i = 0; i < 16; i++) check_eq("mem_word", tbmem[i], ref_mem[i]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
